feature_loader: RTL

Streams an input feature map, one element per handshake, into the feature BRAM write port. It packs eight channel elements into each 64-bit word at the same `h/w/channel-group` address layout that the window-fetch path reads back. It sits ahead of layer 0: the host or DMA fills the first feature region, then the control unit starts the first buffer initialisation. `done` is the hand-off.

---
 rtl/feature_loader_if.sv | 22 ++
 rtl/feature_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/feature_loader_if.sv
// rtl/feature_loader_if.sv - element stream in and feature BRAM write port out for feature_loader
interface feature_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                    s_valid;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    s_ready;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH*8-1:0] wr_data;

    modport master (
        input  s_valid, s_data,
        output s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/feature_loader.sv
// rtl/feature_loader.sv - packs a c/w/h-ordered element stream into 8-lane words for the feature BRAM
// Optional running element checksum: FEATURE_LOADER_CHECKSUM_EN.
module feature_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [7:0]            img_size_i,
    input  logic [7:0]            img_channel_i,
    input  logic [3:0]            h_shift_i,
    input  logic [3:0]            w_shift_i,
    feature_loader_if.master      bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           checksum_o
);
    localparam int WORD_W = DATA_WIDTH * 8;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [7:0]            size_q, size_d;
    logic [7:0]            chan_q, chan_d;
    logic [3:0]            hsh_q, hsh_d;
    logic [3:0]            wsh_q, wsh_d;
    logic [7:0]            c_q, c_d;
    logic [7:0]            w_q, w_d;
    logic [7:0]            h_q, h_d;
    logic [WORD_W-1:0]     pack_q, pack_d, pack_next;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]     wr_data_q, wr_data_d;
    logic                  fire, last_c, last_w, last_h, word_done;

    assign bus.s_ready = (state_q == LOAD);
    assign fire        = bus.s_valid && bus.s_ready;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

    assign last_c    = (c_q == chan_q - 8'd1);
    assign last_w    = (w_q == size_q - 8'd1);
    assign last_h    = (h_q == size_q - 8'd1);
    assign word_done = (c_q[2:0] == 3'd7) || last_c;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        size_d    = size_q;
        chan_d    = chan_q;
        hsh_d     = hsh_q;
        wsh_d     = wsh_q;
        c_d       = c_q;
        w_d       = w_q;
        h_d       = h_q;
        pack_d    = pack_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pack_next = pack_q;
        pack_next[DATA_WIDTH*c_q[2:0] +: DATA_WIDTH] = bus.s_data;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d = base_addr_i;
                    size_d = img_size_i;
                    chan_d = img_channel_i;
                    hsh_d  = h_shift_i;
                    wsh_d  = w_shift_i;
                    c_d    = '0;
                    w_d    = '0;
                    h_d    = '0;
                    pack_d = '0;
                    // Empty loads pass through FLUSH (no write) so done keeps the same two-cycle tail.
                    state_d = (img_size_i == 8'd0 || img_channel_i == 8'd0) ? FLUSH : LOAD;
                end
            end
            LOAD: begin
                if (fire) begin
                    if (word_done) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = base_q + (ADDR_WIDTH'(h_q) << hsh_q)
                                  + (ADDR_WIDTH'(w_q) << wsh_q) + ADDR_WIDTH'(c_q >> 3);
                        wr_data_d = pack_next;
                        pack_d    = '0;
                    end else begin
                        pack_d = pack_next;
                    end
                    if (last_c) begin
                        c_d = '0;
                        if (last_w) begin
                            w_d = '0;
                            if (last_h) begin
                                h_d     = '0;
                                state_d = FLUSH;
                            end else begin
                                h_d = h_q + 8'd1;
                            end
                        end else begin
                            w_d = w_q + 8'd1;
                        end
                    end else begin
                        c_d = c_q + 8'd1;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            size_q    <= '0;
            chan_q    <= '0;
            hsh_q     <= '0;
            wsh_q     <= '0;
            c_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            pack_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            size_q    <= size_d;
            chan_q    <= chan_d;
            hsh_q     <= hsh_d;
            wsh_q     <= wsh_d;
            c_q       <= c_d;
            w_q       <= w_d;
            h_q       <= h_d;
            pack_q    <= pack_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef FEATURE_LOADER_CHECKSUM_EN
    logic [15:0] chk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            chk_q <= '0;
        end else if (fire) begin
            chk_q <= chk_q + 16'(bus.s_data);
        end
    end

    assign checksum_o = chk_q;
`else
    assign checksum_o = 16'd0;
`endif
endmodule
